// File: rtl/button_conditioner.sv
// Three-channel push-button conditioner: polarity fix, two-flop synchroniser,
// stability-counter debounce, press/release pulses and a prioritised press code.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_raw,
    output logic [2:0] btn_level,
    output logic [2:0] btn_press,
    output logic [2:0] btn_release,
    output logic       press_valid,
    output logic [1:0] press_id
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [2:0]            in_s;
    logic [2:0]            s1_r;
    logic [2:0]            s2_r;
    logic [2:0][CNT_W-1:0] cnt_r;
    logic [2:0][CNT_W-1:0] cnt_nxt_s;
    logic [2:0]            level_r;
    logic [2:0]            level_nxt_s;
    logic [2:0]            press_r;
    logic [2:0]            press_nxt_s;
    logic [2:0]            release_r;
    logic [2:0]            release_nxt_s;
    logic                  valid_r;
    logic                  valid_nxt_s;
    logic [1:0]            id_r;
    logic [1:0]            id_nxt_s;

    // Normalise pin polarity so that 1 always means pressed.
    always_comb begin
        if (ACTIVE_LOW) begin
            in_s = ~btn_raw;
        end else begin
            in_s = btn_raw;
        end
    end

    // Two-flop synchroniser per channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 3'b000;
            s2_r <= 3'b000;
        end else begin
            s1_r <= in_s;
            s2_r <= s1_r;
        end
    end

    // Stability counter: any agreement with the current level restarts the count.
    always_comb begin
        level_nxt_s = level_r;
        cnt_nxt_s   = cnt_r;
        for (int i = 0; i < 3; i++) begin
            if (s2_r[i] == level_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
                level_nxt_s[i] = s2_r[i];
                cnt_nxt_s[i]   = CNT_ZERO;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Edge pulses derived from the level about to be registered.
    always_comb begin
        press_nxt_s   = level_nxt_s & ~level_r;
        release_nxt_s = level_r & ~level_nxt_s;
        valid_nxt_s   = |press_nxt_s;
    end

    // Lowest-index press wins the code; releases never produce a code.
    always_comb begin
        id_nxt_s = 2'd0;
        if (press_nxt_s[0]) begin
            id_nxt_s = 2'd1;
        end else if (press_nxt_s[1]) begin
            id_nxt_s = 2'd2;
        end else if (press_nxt_s[2]) begin
            id_nxt_s = 2'd3;
        end else begin
            id_nxt_s = 2'd0;
        end
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {3{CNT_ZERO}};
            level_r   <= 3'b000;
            press_r   <= 3'b000;
            release_r <= 3'b000;
            valid_r   <= 1'b0;
            id_r      <= 2'd0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            level_r   <= level_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
            valid_r   <= valid_nxt_s;
            id_r      <= id_nxt_s;
        end
    end

    assign btn_level   = level_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;
    assign press_valid = valid_r;
    assign press_id    = id_r;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Three-channel input conditioner between the raw board push-buttons and the LED/hit-decode stage. Each channel is synchronised to `clk`, debounced with a stability counter, and presented as a clean level, one-cycle press/release pulses and a prioritised press code. Downstream logic consumes `btn_level` as its button inputs and `press_valid`/`press_id` for hit events.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before a level change is accepted (20 ms at 50 MHz); legal range 1 .. 2^CNT_W−1.
- `CNT_W`, default 20: width of each channel's stability counter.
- `ACTIVE_LOW`, default 0: 1 means the raw pins read 0 when pressed; the pins are inverted before the synchroniser.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_raw`  in  3  raw asynchronous button pins; bit 0 = button 1, bit 2 = button 3.
- `btn_level`  out  3  debounced level, 1 = pressed.
- `btn_press`  out  3  one-cycle pulse per channel on a debounced 0→1 transition.
- `btn_release`  out  3  one-cycle pulse per channel on a debounced 1→0 transition.
- `press_valid`  out  1  high for one cycle when any `btn_press` bit is high.
- `press_id`  out  2  index of the pressed button (1, 2 or 3) while `press_valid` is high; 0 otherwise.

## Operation

- Polarity: `in = ACTIVE_LOW ? ~btn_raw : btn_raw`.
- Synchroniser: two flops per channel (`s1 <= in`, `s2 <= s1`). Only `s2` is used downstream.
- Debounce: each channel has a counter `cnt` (CNT_W bits) and a register `level` (drives `btn_level`). On each edge:
  - If `s2 == level`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES−1`: `level <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - Any disagreement lasting fewer than DEBOUNCE_CYCLES cycles (bounce or glitch) restarts the count and produces no output change. The counter never wraps.
- Pulses: registered on the same edge that updates `level`.
  - `btn_press[i]` = 1 for exactly the cycle in which `level[i]` first reads 1.
  - `btn_release[i]` = 1 for exactly the cycle in which `level[i]` first reads 0.
  - Otherwise both are 0.
- Press code: registered on the same edge as the pulses.
  - `press_valid` = OR of the new press bits.
  - `press_id` = lowest-index channel pressing on that edge: bit0 gives 1, else bit1 gives 2, else bit2 gives 3; 0 when there is no press.
  - Simultaneous presses set every corresponding `btn_press` bit, but `press_id` reports only the lowest index.
  - Releases never assert `press_valid`.
- Channels are fully independent; there is no cross-channel lockout.

## Timing

- Reset value of every flop and output is 0: `s1`, `s2`, `cnt`, `btn_level`, `btn_press`, `btn_release`, `press_valid`, `press_id`. Reset is applied immediately and asynchronously and may be asserted mid-count; all counts are discarded.
- Latency: let edge k be the first edge that samples a new stable `in` value. `s2` changes at edge k+1 and `btn_level` changes at edge k+1+DEBOUNCE_CYCLES. The pulse and `press_valid` coincide with that edge.
- Pulse width is always exactly 1 cycle. The minimum spacing between a press and a release on one channel is DEBOUNCE_CYCLES cycles.
- A button held through reset deassertion is treated as a new press: `btn_press` fires at edge 2+DEBOUNCE_CYCLES counted from the first edge after `rst` falls.
- Outputs are glitch-free registered values; no combinational path runs from `btn_raw` to any output.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, CNT_W=3, ACTIVE_LOW=0.

1. Reset: hold `rst`=1 with `btn_raw`=3'b111 → all outputs 0. Release reset with the buttons still held → `btn_level`=3'b111, `btn_press`=3'b111, `press_valid`=1 and `press_id`=1 at edge 6 after `rst` falls, all for one cycle.
2. Clean press: `btn_raw[1]` goes 0→1 before edge k and is held → `btn_level[1]`=1 at edge k+5; `btn_press[1]`=1, `press_valid`=1 and `press_id`=2 for that single cycle; `btn_release`=0 throughout.
3. Bounce: `btn_raw[0]` toggles 1,0,1,1,1,0 (each for one cycle) and then stays 0 → `btn_level[0]` stays 0; there are no pulses.
4. Simultaneous press: `btn_raw` goes 3'b000→3'b110 on one edge → `btn_press`=3'b110 and `press_id`=2 on one cycle; `btn_level`=3'b110 afterwards.
5. Release: from `btn_level`=3'b001, set `btn_raw`=0 → `btn_release[0]`=1 for one cycle at edge k+5; `press_valid` stays 0 and `press_id` stays 0.
6. Reset mid-count: start a press on `btn_raw[2]`, then assert `rst` at edge k+3 for 2 cycles → outputs go to 0 immediately; after reset deasserts, the press is detected a full 6 edges later, not earlier.
